// File: rtl/phy_rx_word_buffer_pkg.sv
// Shared constants and helpers for the PHY receive word buffer.
// Covers the default geometry, the pointer width and the drop-counter sizing.
package phy_rx_word_buffer_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 2;

  // Drop statistics counter saturates instead of wrapping.
  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Per-cycle buffer operation, encoded as {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

  // Pointers carry one extra wrap bit above the storage index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/phy_rx_buf_mem.sv
// Storage array for the receive word buffer.
// Synchronous write and addressed read; the contents are deliberately never reset.
module phy_rx_buf_mem
  import phy_rx_word_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/phy_rx_word_buffer.sv
// Receive word buffer between the PHY unstriping stage and the link layer.
// Optional drop statistics output enabled by defining PHY_RX_BUF_STATS_EN.
module phy_rx_word_buffer
  import phy_rx_word_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                    clk_f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  input  logic                    clr_ovf,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  count
`ifdef PHY_RX_BUF_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] ONE       = PW'(1);
  localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL    = PW'(AE_THRESH);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_nx;
  logic [PW-1:0]     rd_ptr_nx;
  logic [PW-1:0]     count_nx;
  logic              pop;
  logic              push_acc;
  logic              drop;
  buf_op_e           op;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] head_nx;

  assign pop      = valid_out & ready_in;
  assign push_acc = valid_in & (~full | pop);
  assign drop     = valid_in & full & ~pop;
  assign op       = buf_op_e'({pop, push_acc});

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count;
    case (op)
      OP_PUSH: begin
        wr_ptr_nx = wr_ptr + ONE;
        count_nx  = count + ONE;
      end
      OP_POP: begin
        rd_ptr_nx = rd_ptr + ONE;
        count_nx  = count - ONE;
      end
      OP_BOTH: begin
        wr_ptr_nx = wr_ptr + ONE;
        rd_ptr_nx = rd_ptr + ONE;
      end
      default: begin
      end
    endcase
  end

  // When the incoming word becomes the new head it is not in storage yet,
  // so it bypasses the array straight into the data_out register.
  always_comb begin
    head_nx = mem_rd_data;
    if (push_acc && (count == {{AW{1'b0}}, pop})) begin
      head_nx = data_in;
    end
  end

  phy_rx_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk_f),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr_nx[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_LVL == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      rd_ptr       <= rd_ptr_nx;
      count        <= count_nx;
      valid_out    <= (count_nx != '0);
      if (count_nx != '0) begin
        data_out <= head_nx;
      end
      full         <= (count_nx == DEPTH_LVL);
      empty        <= (count_nx == '0);
      almost_full  <= (count_nx >= AF_LVL);
      almost_empty <= (count_nx <= AE_LVL);
      // A new drop wins over a simultaneous clear.
      overflow     <= drop | (overflow & ~clr_ovf);
    end
  end

`ifdef PHY_RX_BUF_STATS_EN
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (clr_ovf) begin
        drop_cnt <= DROP_CNT_W'(1);
      end else if (drop_cnt != DROP_CNT_MAX) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end else if (clr_ovf) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: doc/phy_rx_word_buffer.md
# phy_rx_word_buffer

Single-clock receive word buffer sitting directly downstream of the PHY receive path. It absorbs the 32-bit words and valid strobe produced by the byte-unstriping stage and presents them to the link-layer consumer through a valid/ready handshake. The upstream PHY has no backpressure, so the block provides buffering, occupancy flags, and sticky overflow reporting for words that arrive while the buffer is full.

## Interface
Parameters:
- DATA_W, 32, word width; matches the PHY receive data_out width.
- DEPTH, 8, number of entries; must be a power of two, ≥ 4.
- AF_THRESH, 6, almost_full asserted when count ≥ AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH.

Ports:
- clk_f  in  1  the single clock; same domain as the PHY receive output.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  word from the PHY receive path.
- valid_in  in  1  data_in is valid this cycle (push request).
- data_out  out  DATA_W  head-of-buffer word.
- valid_out  out  1  data_out holds a valid word.
- ready_in  in  1  consumer accepts data_out this cycle.
- clr_ovf  in  1  clears the sticky overflow flag.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- overflow  out  1  sticky; a word was dropped.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with write and read pointers of $clog2(DEPTH)+1 bits. The MSB is the wrap bit, so full and empty are distinguished by the wrap bit.
- Pop occurs when valid_out && ready_in. Pop is never possible while empty.
- Push is accepted when valid_in && (!full || pop). When full and popping in the same cycle, both happen and count stays at DEPTH.
- Push while full with no pop: the word is dropped, pointers and count are unchanged, and overflow sets.
- overflow stays set until clr_ovf is high at a clock edge. If clr_ovf and a new drop occur in the same cycle, overflow stays set (set wins).
- Simultaneous push and pop when not empty and not full: both pointers advance and count is unchanged.
- Count arithmetic: count_next = count + push_acc − pop. Its range is 0..DEPTH, and it never wraps.
- Pointer wrap: the low bits index storage modulo DEPTH. Crossing DEPTH toggles the wrap bit.
- Reset (any time, including mid-transfer) discards all contents. Stored data is not cleared, only pointers.

## Timing
- Reset values:
  - data_out = 0, valid_out = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (with AF_THRESH > 0), overflow = 0, count = 0.
- All outputs are registered. Flags and count reflect state after the last edge.
- Write-to-read latency is 1 cycle. A word pushed into an empty buffer at edge N shows valid_out = 1 and data_out = that word after edge N.
- data_out updates at the same edge a pop is taken. A back-to-back pop every cycle is sustained while non-empty.
- data_out and valid_out remain stable while valid_out && !ready_in.
- overflow is visible one cycle after the dropped push.

## Configuration
- PHY_RX_BUF_STATS_EN defined:
  - Adds output drop_cnt[7:0]: a saturating count of dropped words (holds at 255).
  - drop_cnt is cleared by reset and by clr_ovf. If clr_ovf and a drop occur in the same cycle, drop_cnt = 1.
- PHY_RX_BUF_STATS_EN undefined:
  - The drop_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- The shared package holds:
  - the default DATA_W, DEPTH, AF_THRESH and AE_THRESH constants;
  - the pointer-width function/constant;
  - the drop-counter width (8) and saturation value.
- One sub-module, phy_rx_buf_mem: a DEPTH×DATA_W storage array with a synchronous write port and an addressed read port, with no reset on the storage.
- Pointer, count, flag and handshake logic live in phy_rx_word_buffer.

## Test plan
- Reset, then push 0x0000_0001..0x0000_0003 on consecutive cycles with ready_in = 0 → count = 3, almost_empty = 0 after the third push, data_out = 0x0000_0001 stable.
- Fill 8 words 0xA0..0xA7, then push 0xFF with no pop → full = 1, overflow = 1 next cycle, count = 8. Draining yields 0xA0..0xA7 in order and no 0xFF. With PHY_RX_BUF_STATS_EN, drop_cnt = 1.
- At full, push 0xB0 with ready_in = 1 in the same cycle → 0xA0 popped, 0xB0 stored, count stays 8, overflow unchanged.
- Continuous push and pop for 20 cycles from an empty buffer → data_out lags data_in by 1 cycle, count ≤ 1, pointers wrap twice with no loss.
- Assert clr_ovf in the same cycle as a drop → overflow remains 1. Assert clr_ovf alone next cycle → overflow = 0.
- Assert reset low mid-drain with count = 5 → next cycle count = 0, empty = 1, valid_out = 0, overflow = 0.
